// File: rtl/vote_session_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vote_session_ctrl_if
// Description : Bus bundle for the three-voter session controller.
//               master : the voting front-end (drives start/vld/val)
//               slave  : vote_session_ctrl (drives ack/voted/busy/done/y/timeout)
// Signals     : start_i      1  session request
//               vld_i/val_i  3  per-voter vote strobe / value (1 = yes)
//               ack_o        3  one-cycle acknowledge per latched vote
//               voted_o      3  voters latched in current/last session
//               busy_o       1  voting window open
//               done_o       1  one-cycle result strobe
//               y_o          1  majority result
//               timeout_o    1  last session ended by window expiry
// Revision    : 1.0 - initial release
// ============================================================================
interface vote_session_ctrl_if;
  logic       start_i;
  logic [2:0] vld_i;
  logic [2:0] val_i;
  logic [2:0] ack_o;
  logic [2:0] voted_o;
  logic       busy_o;
  logic       done_o;
  logic       y_o;
  logic       timeout_o;

  modport master (
    output start_i, vld_i, val_i,
    input  ack_o, voted_o, busy_o, done_o, y_o, timeout_o
  );

  modport slave (
    input  start_i, vld_i, val_i,
    output ack_o, voted_o, busy_o, done_o, y_o, timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/vote_session_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vote_session_ctrl
// Description : Three-voter majority session controller. IDLE -> VOTING on
//               start; each voter may vote once; RESULT (one cycle, done=1)
//               follows completion of all votes or, optionally, window expiry.
// Ports       : clk_i  - clock, rising edge
//               rst_i  - synchronous active-high reset
//               bus    - vote_session_ctrl_if.slave (see interface header)
// Parameters  : WINDOW_CYC - voting window in cycles (2..255), timer builds only
// Macro       : VOTE_TIMEOUT_EN - enables the voting-window timer; when
//               undefined VOTING waits for all three votes, timeout_o = 0
// Revision    : 1.0 - initial release
// ============================================================================
module vote_session_ctrl #(
  parameter int WINDOW_CYC = 16
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  vote_session_ctrl_if.slave  bus
);

  // Out-of-range window values stop elaboration on an unresolvable instance.
  if (WINDOW_CYC < 2 || WINDOW_CYC > 255) begin : g_bad_window_cyc
    illegal_window_cyc_parameter u_bad ();
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTING = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] voted_q, voted_d;
  logic [2:0] votes_q, votes_d;
  logic [2:0] ack_q, ack_d;
  logic       y_q, y_d;
  logic [2:0] new_votes;
  logic       expire;

  // First-time votes only; repeat strobes from already latched voters drop.
  assign new_votes = (state_q == VOTING) ? (bus.vld_i & ~voted_q) : 3'b000;

  function automatic logic majority(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

`ifdef VOTE_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(WINDOW_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  assign expire        = (cnt_q == CNT_LAST);
  assign bus.timeout_o = timeout_q;
`else
  assign expire        = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    voted_d   = voted_q;
    votes_d   = votes_q;
    ack_d     = 3'b000;
    y_d       = y_q;
`ifdef VOTE_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d   = VOTING;
          voted_d   = 3'b000;
          votes_d   = 3'b000;
          y_d       = 1'b0;
`ifdef VOTE_TIMEOUT_EN
          cnt_d     = 8'd0;
          timeout_d = 1'b0;
`endif
        end
      end
      VOTING: begin
        ack_d   = new_votes;
        voted_d = voted_q | new_votes;
        votes_d = votes_q | (bus.val_i & new_votes);
`ifdef VOTE_TIMEOUT_EN
        cnt_d   = cnt_q + 8'd1;
`endif
        if (voted_q == 3'b111 || expire) begin
          state_d = RESULT;
          // Uses the _d votes so a vote landing on the final cycle counts.
          y_d     = majority(votes_d);
`ifdef VOTE_TIMEOUT_EN
          // A last vote arriving on the expiry cycle completes the session.
          timeout_d = (voted_d != 3'b111);
`endif
        end
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      voted_q   <= 3'b000;
      votes_q   <= 3'b000;
      ack_q     <= 3'b000;
      y_q       <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      voted_q   <= voted_d;
      votes_q   <= votes_d;
      ack_q     <= ack_d;
      y_q       <= y_d;
`ifdef VOTE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.voted_o = voted_q;
  assign bus.busy_o  = (state_q == VOTING);
  assign bus.done_o  = (state_q == RESULT);
  assign bus.y_o     = y_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vote_session_ctrl
// Description : Self-checking bench for vote_session_ctrl: a table of
//               one-cycle vectors {rst, start, vld, val -> expected outputs}
//               followed by hand-written multi-cycle window sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_session_ctrl;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [2:0] vld;
    logic [2:0] val;
    logic [2:0] ack;
    logic [2:0] voted;
    logic       busy;
    logic       done;
    logic       y;
    logic       to;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vote_session_ctrl_if ifc ();

  vote_session_ctrl #(.WINDOW_CYC(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  function automatic logic [9:0] outs();
    return {ifc.ack_o, ifc.voted_o, ifc.busy_o, ifc.done_o, ifc.y_o, ifc.timeout_o};
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] vl,
                              input logic [2:0] va, input logic [2:0] a,
                              input logic [2:0] vt, input logic b, input logic d,
                              input logic yy, input logic t);
    vec_t v;
    v = '{rst:r, start:s, vld:vl, val:va, ack:a, voted:vt, busy:b, done:d, y:yy, to:t};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] vl, input logic [2:0] va);
    ifc.start_i = s;
    ifc.vld_i   = vl;
    ifc.val_i   = va;
  endtask

  vec_t vq[$];

  initial begin
    int n;
    drive(1'b0, 3'b000, 3'b000);

    //          rst start vld     val     ack     voted   bsy dn y  to
    vq.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0)); // reset
    vq.push_back(mk(0, 0, 3'b111, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0)); // vld in IDLE
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0)); // start
    vq.push_back(mk(0, 1, 3'b111, 3'b110, 3'b111, 3'b111, 1, 0, 0, 0)); // all at once
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b111, 0, 1, 1, 0)); // RESULT
    vq.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0, 0, 1, 0)); // IDLE hold
    vq.push_back(mk(0, 0, 3'b001, 3'b001, 3'b000, 3'b111, 0, 0, 1, 0)); // vld in IDLE
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0)); // start clears
    vq.push_back(mk(0, 0, 3'b001, 3'b001, 3'b001, 3'b001, 1, 0, 0, 0)); // v0 yes
    vq.push_back(mk(0, 0, 3'b001, 3'b000, 3'b000, 3'b001, 1, 0, 0, 0)); // v0 re-vote
    vq.push_back(mk(0, 0, 3'b010, 3'b000, 3'b010, 3'b011, 1, 0, 0, 0)); // v1 no
    vq.push_back(mk(0, 0, 3'b100, 3'b000, 3'b100, 3'b111, 1, 0, 0, 0)); // v2 no
    vq.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0)); // RESULT y=0
    vq.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0)); // IDLE
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0)); // start
    vq.push_back(mk(0, 0, 3'b001, 3'b111, 3'b001, 3'b001, 1, 0, 0, 0)); // val masked
    vq.push_back(mk(0, 0, 3'b110, 3'b001, 3'b110, 3'b111, 1, 0, 0, 0)); // v1,v2 no
    vq.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0)); // y=0
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0)); // start in RESULT ignored
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0)); // start
    vq.push_back(mk(0, 0, 3'b001, 3'b001, 3'b001, 3'b001, 1, 0, 0, 0)); // v0 yes
    vq.push_back(mk(1, 1, 3'b110, 3'b110, 3'b000, 3'b000, 0, 0, 0, 0)); // reset mid-vote
    vq.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0)); // no DONE
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0)); // clean start
    vq.push_back(mk(0, 1, 3'b111, 3'b011, 3'b111, 3'b111, 1, 0, 0, 0)); // held start
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b111, 0, 1, 1, 0)); // RESULT y=1
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b111, 0, 0, 1, 0)); // IDLE, y held
    vq.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0, 0, 1, 0)); // IDLE, y held
    vq.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0)); // next start
    vq.push_back(mk(0, 0, 3'b111, 3'b000, 3'b111, 3'b111, 1, 0, 0, 0)); // all no
    vq.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0)); // y=0
    vq.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0)); // IDLE

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst;
      drive(vq[i].start, vq[i].vld, vq[i].val);
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vq[i].ack, vq[i].voted, vq[i].busy, vq[i].done, vq[i].y, vq[i].to}));
    end
    drive(1'b0, 3'b000, 3'b000);

`ifdef VOTE_TIMEOUT_EN
    // Window expiry with two yes votes: 16 VOTING cycles then RESULT.
    drive(1'b1, 3'b000, 3'b000);
    step();
    n = ifc.busy_o ? 1 : 0;
    drive(1'b0, 3'b110, 3'b110);
    for (int k = 0; k < 40 && !ifc.done_o; k++) begin
      step();
      drive(1'b0, 3'b000, 3'b000);
      if (ifc.busy_o) n++;
    end
    chk("win_len", 32'(n), 32'd16);
    chk("expire_res", 32'(outs()), 32'({3'b000, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1}));
    step();

    // Final vote lands on counter value 15: accepted, no timeout.
    drive(1'b1, 3'b000, 3'b000);
    step();
    drive(1'b0, 3'b011, 3'b001);
    step();
    drive(1'b0, 3'b000, 3'b000);
    repeat (14) step();
    chk("pre_last_busy", 32'(outs()), 32'({3'b000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0}));
    drive(1'b0, 3'b100, 3'b100);
    step();
    drive(1'b0, 3'b000, 3'b000);
    chk("last_vote_res", 32'(outs()), 32'({3'b100, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0}));
    step();
`else
    // Without the timer VOTING waits indefinitely for the third vote.
    drive(1'b1, 3'b000, 3'b000);
    step();
    drive(1'b0, 3'b011, 3'b011);
    step();
    drive(1'b0, 3'b000, 3'b000);
    repeat (40) step();
    chk("no_timer_wait", 32'(outs()), 32'({3'b000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0}));
    drive(1'b0, 3'b100, 3'b000);
    step();
    drive(1'b0, 3'b000, 3'b000);
    chk("late_vote", 32'(outs()), 32'({3'b100, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0}));
    step();
    chk("late_res", 32'(outs()), 32'({3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0}));
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter WINDOW_CYC, default 16, SHALL set the voting window length in clock cycles; legal range 2..255.
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 RST  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 START  input  1  SHALL request a new voting session; it is sampled only in IDLE.
REQ-005 VLD  input  3  SHALL be the per-voter vote strobe; bit i belongs to voter i.
REQ-006 VAL  input  3  SHALL be the per-voter vote value (1 = yes), qualified by VLD[i].
REQ-007 ACK  output  3  SHALL pulse bit i for one cycle when voter i's vote is latched.
REQ-008 VOTED  output  3  SHALL flag the voters whose vote is latched in the current or last session.
REQ-009 BUSY  output  1  SHALL be high while in VOTING.
REQ-010 DONE  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-011 Y  output  1  SHALL be the majority result: at least two latched yes votes.
REQ-012 TIMEOUT  output  1  SHALL flag that the last session ended by window expiry.

Function
REQ-013 FSM SHALL have three states: IDLE, VOTING and RESULT.
REQ-014 IDLE with START=1 SHALL move to VOTING next cycle and clear VOTED, the latched votes, Y, TIMEOUT and the window counter.
REQ-015 In VOTING, VLD[i]=1 with VOTED[i]=0 SHALL latch VAL[i], set VOTED[i], and pulse ACK[i] on the next cycle.
REQ-016 Repeat votes (VLD[i]=1 with VOTED[i]=1) SHALL be ignored with no ACK; a vote cannot be changed.
REQ-017 Multiple VLD bits in the same cycle SHALL all be accepted in that cycle.
REQ-018 VOTING SHALL move to RESULT on the cycle after VOTED becomes 3'b111.
REQ-019 RESULT SHALL last exactly one cycle with DONE=1 and Y valid, then return to IDLE.
REQ-020 Voters that have not voted SHALL count as no.
REQ-021 Y, VOTED and TIMEOUT SHALL hold their values from RESULT through IDLE until the next accepted START.
REQ-022 START in VOTING or RESULT SHALL be ignored, with no effect and no queuing.
REQ-023 VLD in IDLE or RESULT SHALL be ignored and SHALL NOT raise ACK.
REQ-024 Y SHALL be registered, computed from the latched votes including any vote accepted in the final VOTING cycle.

Reset
REQ-025 RST=1 SHALL force IDLE and zero ACK, VOTED, BUSY, DONE, Y, TIMEOUT, the latched votes and the window counter on the next edge, overriding all inputs.
REQ-026 RST asserted in VOTING or RESULT SHALL abort the session with no DONE pulse.

Configuration
REQ-027 Macro VOTE_TIMEOUT_EN SHALL control the voting-window timer.
REQ-028 With VOTE_TIMEOUT_EN defined, the counter SHALL increment each VOTING cycle from 0.
REQ-029 With VOTE_TIMEOUT_EN defined, reaching WINDOW_CYC-1 with VOTED not equal to 3'b111 SHALL move to RESULT next cycle with TIMEOUT=1.
REQ-030 With VOTE_TIMEOUT_EN defined, if the final vote and expiry coincide, the vote SHALL be accepted and TIMEOUT=0, because completion wins.
REQ-031 With VOTE_TIMEOUT_EN undefined, there SHALL be no counter, VOTING SHALL wait indefinitely for all three votes, and TIMEOUT SHALL be constant 0.

Verification
REQ-032 START; VLD=111/VAL=110 in one cycle -> ACK=111 next cycle, DONE and Y=1 the cycle after, VOTED=111, TIMEOUT=0.
REQ-033 START; voter0 yes, voter1 no, voter2 no on separate cycles -> three single ACK pulses, DONE with Y=0; voter0 re-votes no before completion -> no ACK, result unchanged.
REQ-034 With VOTE_TIMEOUT_EN and WINDOW_CYC=16: START; only voter1 and voter2 vote yes -> DONE at VOTING cycle 16, Y=1, TIMEOUT=1, VOTED=110.
REQ-035 With VOTE_TIMEOUT_EN: final vote on counter value 15 -> ACK asserted, TIMEOUT=0, Y reflects all three votes.
REQ-036 Mid-VOTING: RST=1 for one cycle -> all outputs 0 next cycle, no DONE; later START runs a clean session.
REQ-037 START held high through VOTING and RESULT -> exactly one session per IDLE visit, and Y stays stable between DONE and the next accepted START.
